// File: rtl/ofs_fim_pcie_ss_shims_pkg.sv
// Shared types for the PCIe SS RX shims: header width, RX framing
// states and the saturating error-count type.
package ofs_fim_pcie_ss_shims_pkg;

   localparam int SB_HDR_WIDTH = 256;

   typedef enum logic [1:0] {
      ST_SOP   = 2'd0,
      ST_MID   = 2'd1,
      ST_FLUSH = 2'd2
   } rx_state_e;

   typedef logic [15:0] err_cnt_t;

   localparam err_cnt_t ERR_CNT_MAX = 16'hFFFF;

endpackage

// File: rtl/ofs_fim_pcie_ss_pipe_rx_sb2ib.sv
// RX side-band to in-band header converter with a registered output stage.
// Define OFS_FIM_PCIE_SS_RX_SB_CHECK_EN to enable hvalid framing checks.
module ofs_fim_pcie_ss_pipe_rx_sb2ib #(
   parameter int TDATA_WIDTH = 512,
   parameter int TKEEP_WIDTH = TDATA_WIDTH/8,
   parameter int HDR_WIDTH   = ofs_fim_pcie_ss_shims_pkg::SB_HDR_WIDTH
) (
   input  logic                   hip_clk,
   input  logic                   hip_rst_n,
   input  logic                   ss_app_st_rx_tvalid,
   input  logic [TDATA_WIDTH-1:0] ss_app_st_rx_tdata,
   input  logic [TKEEP_WIDTH-1:0] ss_app_st_rx_tkeep,
   input  logic                   ss_app_st_rx_tlast,
   input  logic                   ss_app_st_rx_tuser_vendor,
   input  logic                   ss_app_st_rx_tuser_hvalid,
   input  logic [HDR_WIDTH-1:0]   ss_app_st_rx_tuser_hdr,
   output logic                   app_ss_st_rx_tready,
   output logic                   rx_ib_tvalid,
   output logic [TDATA_WIDTH-1:0] rx_ib_tdata,
   output logic [TKEEP_WIDTH-1:0] rx_ib_tkeep,
   output logic                   rx_ib_tlast,
   output logic                   rx_ib_tuser_vendor,
   input  logic                   rx_ib_tready,
   output logic                   rx_sb_err,
   output logic [15:0]            rx_sb_err_cnt
);

   import ofs_fim_pcie_ss_shims_pkg::*;

   localparam int DH = TDATA_WIDTH - HDR_WIDTH;
   localparam int KH = TKEEP_WIDTH / 2;
   localparam int HK = HDR_WIDTH / 8;
   localparam int CK = TKEEP_WIDTH - KH;

   rx_state_e              state_q, state_d;
   logic [HDR_WIDTH-1:0]   carry_q, carry_d;
   logic [CK-1:0]          ckeep_q, ckeep_d;
   logic                   vend_q, vend_d;

   logic                   ov_q, ov_d;
   logic [TDATA_WIDTH-1:0] od_q, od_d;
   logic [TKEEP_WIDTH-1:0] ok_q, ok_d;
   logic                   ol_q, ol_d;
   logic                   ou_q, ou_d;

   logic                   out_free;
   logic                   acc;
   logic                   hi_empty;
   logic                   is_sop;

   assign out_free = !ov_q || rx_ib_tready;
   assign app_ss_st_rx_tready = (state_q != ST_FLUSH) && out_free;
   assign acc = ss_app_st_rx_tvalid && app_ss_st_rx_tready;
   assign hi_empty = ~|ss_app_st_rx_tkeep[TKEEP_WIDTH-1:KH];
   assign is_sop = (state_q == ST_SOP);

   always_comb begin
      state_d = state_q;
      carry_d = carry_q;
      ckeep_d = ckeep_q;
      vend_d  = vend_q;
      ov_d    = ov_q;
      od_d    = od_q;
      ok_d    = ok_q;
      ol_d    = ol_q;
      ou_d    = ou_q;
      if (out_free) begin
         ov_d = 1'b0;
      end
      unique case (state_q)
         ST_SOP, ST_MID: begin
            if (acc) begin
               ov_d    = 1'b1;
               carry_d = ss_app_st_rx_tdata[TDATA_WIDTH-1:DH];
               ckeep_d = ss_app_st_rx_tkeep[TKEEP_WIDTH-1:KH];
               if (is_sop) begin
                  od_d   = {ss_app_st_rx_tdata[DH-1:0],
                            ss_app_st_rx_tuser_hdr};
                  ok_d   = {ss_app_st_rx_tkeep[KH-1:0], {HK{1'b1}}};
                  vend_d = ss_app_st_rx_tuser_vendor;
                  ou_d   = ss_app_st_rx_tuser_vendor;
               end else begin
                  od_d = {ss_app_st_rx_tdata[DH-1:0], carry_q};
                  ok_d = {ss_app_st_rx_tkeep[KH-1:0], ckeep_q};
                  ou_d = vend_q;
               end
               // Upper half still holding bytes needs one extra beat
               if (ss_app_st_rx_tlast && hi_empty) begin
                  ol_d    = 1'b1;
                  state_d = ST_SOP;
               end else if (ss_app_st_rx_tlast) begin
                  ol_d    = 1'b0;
                  state_d = ST_FLUSH;
               end else begin
                  ol_d    = 1'b0;
                  state_d = ST_MID;
               end
            end
         end
         ST_FLUSH: begin
            if (out_free) begin
               ov_d    = 1'b1;
               od_d    = {{DH{1'b0}}, carry_q};
               ok_d    = {{KH{1'b0}}, ckeep_q};
               ol_d    = 1'b1;
               ou_d    = vend_q;
               carry_d = '0;
               ckeep_d = '0;
               state_d = ST_SOP;
            end
         end
         default: begin
            state_d = ST_SOP;
         end
      endcase
   end

   always_ff @(posedge hip_clk or negedge hip_rst_n) begin
      if (!hip_rst_n) begin
         state_q <= ST_SOP;
         carry_q <= '0;
         ckeep_q <= '0;
         vend_q  <= 1'b0;
         ov_q    <= 1'b0;
         od_q    <= '0;
         ok_q    <= '0;
         ol_q    <= 1'b0;
         ou_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         carry_q <= carry_d;
         ckeep_q <= ckeep_d;
         vend_q  <= vend_d;
         ov_q    <= ov_d;
         od_q    <= od_d;
         ok_q    <= ok_d;
         ol_q    <= ol_d;
         ou_q    <= ou_d;
      end
   end

   assign rx_ib_tvalid       = ov_q;
   assign rx_ib_tdata        = od_q;
   assign rx_ib_tkeep        = ok_q;
   assign rx_ib_tlast        = ol_q;
   assign rx_ib_tuser_vendor = ou_q;

`ifdef OFS_FIM_PCIE_SS_RX_SB_CHECK_EN
   logic     err_q;
   err_cnt_t cnt_q;
   logic     err_hit;

   assign err_hit = acc &&
      ((is_sop && !ss_app_st_rx_tuser_hvalid) ||
       ((state_q == ST_MID) && ss_app_st_rx_tuser_hvalid));

   always_ff @(posedge hip_clk or negedge hip_rst_n) begin
      if (!hip_rst_n) begin
         err_q <= 1'b0;
         cnt_q <= '0;
      end else if (err_hit) begin
         err_q <= 1'b1;
         if (cnt_q != ERR_CNT_MAX) begin
            cnt_q <= cnt_q + err_cnt_t'(1);
         end
      end
   end

   assign rx_sb_err     = err_q;
   assign rx_sb_err_cnt = cnt_q;
`else
   logic unused_hvalid;
   assign unused_hvalid = ss_app_st_rx_tuser_hvalid;
   assign rx_sb_err     = 1'b0;
   assign rx_sb_err_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_ofs_fim_pcie_ss_pipe_rx_sb2ib.sv
// Directed bench for the RX side-band to in-band converter.
// Error expectations follow OFS_FIM_PCIE_SS_RX_SB_CHECK_EN.
module tb_ofs_fim_pcie_ss_pipe_rx_sb2ib;

   logic         clk;
   logic         rst_n;
   logic         in_v;
   logic [511:0] in_d;
   logic [63:0]  in_k;
   logic         in_l;
   logic         in_vend;
   logic         in_hv;
   logic [255:0] in_h;
   logic         in_rdy;
   logic         ob_v;
   logic [511:0] ob_d;
   logic [63:0]  ob_k;
   logic         ob_l;
   logic         ob_vend;
   logic         ob_rdy;
   logic         err;
   logic [15:0]  errcnt;

   int n_chk = 0;
   int n_pass = 0;

   ofs_fim_pcie_ss_pipe_rx_sb2ib dut (
      .hip_clk                   (clk),
      .hip_rst_n                 (rst_n),
      .ss_app_st_rx_tvalid       (in_v),
      .ss_app_st_rx_tdata        (in_d),
      .ss_app_st_rx_tkeep        (in_k),
      .ss_app_st_rx_tlast        (in_l),
      .ss_app_st_rx_tuser_vendor (in_vend),
      .ss_app_st_rx_tuser_hvalid (in_hv),
      .ss_app_st_rx_tuser_hdr    (in_h),
      .app_ss_st_rx_tready       (in_rdy),
      .rx_ib_tvalid              (ob_v),
      .rx_ib_tdata               (ob_d),
      .rx_ib_tkeep               (ob_k),
      .rx_ib_tlast               (ob_l),
      .rx_ib_tuser_vendor        (ob_vend),
      .rx_ib_tready              (ob_rdy),
      .rx_sb_err                 (err),
      .rx_sb_err_cnt             (errcnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [511:0] act,
                      input logic [511:0] exp);
      n_chk++;
      if (act !== exp)
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      else
         n_pass++;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic [511:0] d;
      logic [63:0]  k;
      logic [255:0] h;
      logic         vend;
      int           nb;
      logic [63:0]  k0;
      logic         l0;
      logic [63:0]  k1;
   } vec_t;

   vec_t         v[5];
   logic [511:0] dq[4];
   logic [63:0]  kq[4];
   logic [511:0] ed[4];
   logic [255:0] hq;
   logic [511:0] sn_d;
   logic [63:0]  sn_k;
   logic         sn_l;
   logic         have_snap;
   logic         acc_in;
   logic [31:0]  w;
   logic         exp_err;
   logic [15:0]  exp_cnt;
   int           i_idx;
   int           o_idx;
   int           cyc;

   initial begin
      v[0] = '{d: {16{32'h1111_2222}}, k: 64'h0,
               h: {32{8'hA5}}, vend: 1'b0, nb: 1,
               k0: 64'h0000_0000_FFFF_FFFF, l0: 1'b1, k1: 64'h0};
      v[1] = '{d: {16{32'h3344_5566}},
               k: 64'h0000_0000_FFFF_FFFF,
               h: {8{32'hC0DE_0001}}, vend: 1'b0, nb: 1,
               k0: {64{1'b1}}, l0: 1'b1, k1: 64'h0};
      v[2] = '{d: {{8{32'hAAAA_0002}}, {8{32'h5555_0002}}},
               k: {64{1'b1}},
               h: {8{32'hBEEF_0002}}, vend: 1'b1, nb: 2,
               k0: {64{1'b1}}, l0: 1'b0,
               k1: 64'h0000_0000_FFFF_FFFF};
      v[3] = '{d: {{8{32'hDEAD_0003}}, {8{32'h7777_0003}}},
               k: 64'h0000_00FF_FFFF_FFFF,
               h: {8{32'h0BAD_0003}}, vend: 1'b0, nb: 2,
               k0: {64{1'b1}}, l0: 1'b0,
               k1: 64'h0000_0000_0000_00FF};
      v[4] = '{d: {16{32'h9876_0004}},
               k: 64'h0000_0000_0000_FFFF,
               h: {8{32'hF00D_0004}}, vend: 1'b1, nb: 1,
               k0: 64'h0000_FFFF_FFFF_FFFF, l0: 1'b1, k1: 64'h0};

      rst_n = 1'b0;
      in_v = 1'b0; in_d = '0; in_k = '0; in_l = 1'b0;
      in_vend = 1'b0; in_hv = 1'b0; in_h = '0;
      ob_rdy = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_tvalid", 512'(ob_v), 512'(0));
      chk("rst_err", 512'(err), 512'(0));
      chk("rst_errcnt", 512'(errcnt), 512'(0));
      rst_n = 1'b1;
      #1;
      chk("rst_tready", 512'(in_rdy), 512'(1));
      tick();

      // single-beat packets from the table
      for (int i = 0; i < 5; i++) begin
         in_v = 1'b1; in_d = v[i].d; in_k = v[i].k; in_l = 1'b1;
         in_vend = v[i].vend; in_hv = 1'b1; in_h = v[i].h;
         #1;
         chk($sformatf("v%0d_in_rdy", i), 512'(in_rdy), 512'(1));
         tick();
         in_v = 1'b0;
         chk($sformatf("v%0d_b0_v", i), 512'(ob_v), 512'(1));
         chk($sformatf("v%0d_b0_d", i), ob_d,
             {v[i].d[255:0], v[i].h});
         chk($sformatf("v%0d_b0_k", i), 512'(ob_k), 512'(v[i].k0));
         chk($sformatf("v%0d_b0_l", i), 512'(ob_l), 512'(v[i].l0));
         chk($sformatf("v%0d_b0_u", i), 512'(ob_vend), 512'(v[i].vend));
         if (v[i].nb == 2) begin
            chk($sformatf("v%0d_flush_rdy", i), 512'(in_rdy), 512'(0));
            tick();
            chk($sformatf("v%0d_b1_v", i), 512'(ob_v), 512'(1));
            chk($sformatf("v%0d_b1_d", i), ob_d,
                {256'h0, v[i].d[511:256]});
            chk($sformatf("v%0d_b1_k", i), 512'(ob_k), 512'(v[i].k1));
            chk($sformatf("v%0d_b1_l", i), 512'(ob_l), 512'(1));
            chk($sformatf("v%0d_b1_u", i), 512'(ob_vend),
                512'(v[i].vend));
            chk($sformatf("v%0d_b1_rdy", i), 512'(in_rdy), 512'(1));
         end
         tick();
         chk($sformatf("v%0d_idle", i), 512'(ob_v), 512'(0));
      end

      // back-to-back 32B packets, no idle between them
      in_v = 1'b1; in_d = {16{32'h0A0A_0005}};
      in_k = 64'h0000_0000_FFFF_FFFF; in_l = 1'b1;
      in_vend = 1'b0; in_hv = 1'b1; in_h = {8{32'h4444_0005}};
      tick();
      in_d = {16{32'h0B0B_0006}}; in_h = {8{32'h4444_0006}};
      #1;
      chk("b2b_rdy", 512'(in_rdy), 512'(1));
      chk("b2b_a_d", ob_d, {{8{32'h0A0A_0005}}, {8{32'h4444_0005}}});
      chk("b2b_a_l", 512'(ob_l), 512'(1));
      tick();
      in_v = 1'b0;
      chk("b2b_b_v", 512'(ob_v), 512'(1));
      chk("b2b_b_d", ob_d, {{8{32'h0B0B_0006}}, {8{32'h4444_0006}}});
      tick();

      // 4-beat packet with rx_ib_tready toggling
      hq = {8{32'h5A5A_0007}};
      for (int i = 0; i < 4; i++) begin
         w = 32'h7000_0000 + 32'(2 * i);
         dq[i] = {{8{w + 32'h1}}, {8{w}}};
         kq[i] = (i == 3) ? 64'h0000_0000_FFFF_FFFF : {64{1'b1}};
      end
      ed[0] = {dq[0][255:0], hq};
      for (int i = 1; i < 4; i++)
         ed[i] = {dq[i][255:0], dq[i-1][511:256]};
      i_idx = 0; o_idx = 0; cyc = 0; have_snap = 1'b0;
      while (o_idx < 4 && cyc < 60) begin
         ob_rdy = (cyc % 2) == 0;
         if (i_idx < 4) begin
            in_v = 1'b1; in_d = dq[i_idx]; in_k = kq[i_idx];
            in_l = (i_idx == 3); in_hv = (i_idx == 0);
            in_vend = (i_idx == 0); in_h = hq;
         end else begin
            in_v = 1'b0;
         end
         #1;
         if (have_snap) begin
            chk("bp_hold_d", ob_d, sn_d);
            chk("bp_hold_k", 512'(ob_k), 512'(sn_k));
            chk("bp_hold_l", 512'(ob_l), 512'(sn_l));
            have_snap = 1'b0;
         end
         acc_in = in_v && in_rdy;
         if (ob_v && ob_rdy) begin
            chk($sformatf("bp_b%0d_d", o_idx), ob_d, ed[o_idx]);
            chk($sformatf("bp_b%0d_k", o_idx), 512'(ob_k),
                512'({64{1'b1}}));
            chk($sformatf("bp_b%0d_l", o_idx), 512'(ob_l),
                512'(o_idx == 3));
            chk($sformatf("bp_b%0d_u", o_idx), 512'(ob_vend), 512'(1));
            o_idx++;
         end else if (ob_v) begin
            sn_d = ob_d; sn_k = ob_k; sn_l = ob_l;
            have_snap = 1'b1;
         end
         tick();
         if (acc_in) i_idx++;
         cyc++;
      end
      chk("bp_beats", 512'(o_idx), 512'(4));
      in_v = 1'b0; ob_rdy = 1'b1;
      tick();
      tick();

      // reset after the second beat of a 4-beat packet
      in_v = 1'b1; in_d = {16{32'h1234_0008}}; in_k = {64{1'b1}};
      in_l = 1'b0; in_vend = 1'b1; in_hv = 1'b1;
      in_h = {8{32'h6666_0008}};
      tick();
      in_d = {16{32'h1234_0009}}; in_hv = 1'b0;
      tick();
      in_v = 1'b0;
      chk("mr_pre_v", 512'(ob_v), 512'(1));
      rst_n = 1'b0;
      #1;
      chk("mr_rst_v", 512'(ob_v), 512'(0));
      chk("mr_rst_err", 512'(err), 512'(0));
      tick();
      rst_n = 1'b1;
      in_v = 1'b1; in_d = {{8{32'hCAFE_000A}}, {8{32'hFACE_000A}}};
      in_k = 64'h0000_0000_FFFF_FFFF; in_l = 1'b1; in_vend = 1'b0;
      in_hv = 1'b1; in_h = {8{32'h7777_000A}};
      #1;
      chk("mr_post_rdy", 512'(in_rdy), 512'(1));
      tick();
      in_v = 1'b0;
      chk("mr_post_v", 512'(ob_v), 512'(1));
      chk("mr_post_d", ob_d, {{8{32'hFACE_000A}}, {8{32'h7777_000A}}});
      chk("mr_post_k", 512'(ob_k), 512'({64{1'b1}}));
      chk("mr_post_l", 512'(ob_l), 512'(1));
      chk("mr_post_u", 512'(ob_vend), 512'(0));
      chk("mr_post_err", 512'(err), 512'(0));
      tick();

      // SOP beat without hvalid
`ifdef OFS_FIM_PCIE_SS_RX_SB_CHECK_EN
      exp_err = 1'b1; exp_cnt = 16'd1;
`else
      exp_err = 1'b0; exp_cnt = 16'd0;
`endif
      in_v = 1'b1; in_d = {16{32'h0E0E_000B}};
      in_k = 64'h0000_0000_FFFF_FFFF; in_l = 1'b1;
      in_hv = 1'b0; in_h = {8{32'h8888_000B}};
      tick();
      in_v = 1'b0;
      chk("hv_err", 512'(err), 512'(exp_err));
      chk("hv_errcnt", 512'(errcnt), 512'(exp_cnt));
      chk("hv_data", ob_d, {{8{32'h0E0E_000B}}, {8{32'h8888_000B}}});
      tick();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
